// File: rtl/alu_seq.sv
// Multi-cycle shift / multiply sequencer driving an external 16-bit ALU.
// Optional macro ALU_SEQ_EARLY_EXIT_EN: MUL stops once the remaining multiplier is zero.
module alu_seq #(
    parameter int SHAMT_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [15:0] alu_y
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SAR  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [3:0] CTL_ADD = 4'd0;
    localparam logic [3:0] CTL_SHL = 4'd6;
    localparam logic [3:0] CTL_SHR = 4'd7;
    localparam logic [3:0] CTL_SAR = 4'd8;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [15:0] work_reg, work_next;
    logic [15:0] mcand_reg, mcand_next;
    logic [15:0] mplier_reg, mplier_next;
    logic [4:0]  count_reg, count_next;
    logic [4:0]  n_reg, n_next;
    logic [15:0] result_reg, result_next;
    logic        zero_reg, zero_next;

    logic        load_result;
    logic [15:0] load_value;
    logic [15:0] step_work;
    logic        last_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= 3'd0;
            work_reg   <= 16'd0;
            mcand_reg  <= 16'd0;
            mplier_reg <= 16'd0;
            count_reg  <= 5'd0;
            n_reg      <= 5'd0;
            result_reg <= 16'd0;
            zero_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            work_reg   <= work_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            n_reg      <= n_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        work_next   = work_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        count_next  = count_reg;
        n_next      = n_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        alu_a       = 16'd0;
        alu_b       = 16'd0;
        alu_control = CTL_ADD;
        load_result = 1'b0;
        load_value  = 16'd0;
        step_work   = work_reg;
        last_step   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next     = op;
                    count_next  = 5'd0;
                    work_next   = opa;
                    mcand_next  = opa;
                    mplier_next = opb;
                    if (op == OP_MUL) begin
                        work_next  = 16'd0;
                        n_next     = 5'd16;
                        state_next = RUN;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                        if (opb == 16'd0) begin
                            state_next  = DONE;
                            load_result = 1'b1;
                            load_value  = 16'd0;
                        end
`endif
                    end else if (op <= OP_SAR) begin
                        n_next = 5'(opb[SHAMT_BITS-1:0]);
                        if (opb[SHAMT_BITS-1:0] == '0) begin
                            state_next  = DONE;
                            load_result = 1'b1;
                            load_value  = opa;
                        end else begin
                            state_next = RUN;
                        end
                    end else begin
                        // Reserved ops finish immediately with a zero result.
                        state_next  = DONE;
                        load_result = 1'b1;
                        load_value  = 16'd0;
                    end
                end
            end

            RUN: begin
                alu_a      = work_reg;
                count_next = count_reg + 5'd1;
                last_step  = (count_next == n_reg);
                if (op_reg == OP_MUL) begin
                    alu_b       = mcand_reg;
                    alu_control = CTL_ADD;
                    step_work   = mplier_reg[0] ? alu_y : work_reg;
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                    if (mplier_next == 16'd0)
                        last_step = 1'b1;
`endif
                end else begin
                    step_work = alu_y;
                    case (op_reg)
                        OP_SHR:  alu_control = CTL_SHR;
                        OP_SAR:  alu_control = CTL_SAR;
                        default: alu_control = CTL_SHL;
                    endcase
                end
                work_next = step_work;
                if (last_step) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    load_value  = step_work;
                end
            end

            DONE: state_next = IDLE;

            default: state_next = IDLE;
        endcase

        if (load_result) begin
            result_next = load_value;
            zero_next   = (load_value == 16'd0);
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with a behavioural ALU and an arithmetic reference model.
module tb_alu_seq;

    localparam int SHAMT_BITS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opa, opb;
    logic        busy, done, zero;
    logic [15:0] result, alu_a, alu_b, alu_y;
    logic [3:0]  alu_control;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.SHAMT_BITS(SHAMT_BITS)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_y(alu_y)
    );

    // External ALU the sequencer talks to.
    always_comb begin
        case (alu_control)
            4'd0:    alu_y = alu_a + alu_b;
            4'd6:    alu_y = {alu_a[14:0], 1'b0};
            4'd7:    alu_y = {1'b0, alu_a[15:1]};
            4'd8:    alu_y = {alu_a[15], alu_a[15:1]};
            default: alu_y = 16'hDEAD;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        int sh;
        int prod;
        sh = int'(b) % (1 << SHAMT_BITS);
        case (o)
            3'd0:    return 16'(int'(a) * (1 << sh));
            3'd1:    return 16'(int'(a) / (1 << sh));
            3'd2:    return 16'($signed(a) >>> sh);
            3'd3: begin
                prod = int'(a) * int'(b);
                return 16'(prod);
            end
            default: return 16'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [15:0] b);
        int n;
        n = 0;
        case (o)
            3'd0, 3'd1, 3'd2: n = int'(b) % (1 << SHAMT_BITS);
            3'd3: begin
`ifdef ALU_SEQ_EARLY_EXIT_EN
                for (int i = 0; i < 16; i++)
                    if (b[i]) n = i + 1;
`else
                n = 16;
`endif
            end
            default: n = 0;
        endcase
        return n;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input bit hammer);
        logic [15:0] exp_r;
        int exp_n, cycles, shl_cycles, stale;
        exp_r = ref_result(o, a, b);
        exp_n = ref_latency(o, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        if (!hammer) start = 1'b0;
        op = 3'($urandom); opa = 16'($urandom); opb = 16'($urandom);
        check("busy_after_start", busy, exp_n > 0);
        cycles = 0; shl_cycles = 0; stale = 0;
        while (!done && cycles < 60) begin
            if (busy && alu_control == 4'd6) shl_cycles++;
            if (!busy && (alu_a != 0 || alu_b != 0 || alu_control != 0)) stale++;
            @(posedge clk); #1;
            cycles++;
            if (hammer) begin
                op = 3'($urandom); opa = 16'($urandom); opb = 16'($urandom);
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("latency", cycles, exp_n);
        check("result", result, exp_r);
        check("zero", zero, exp_r == 16'd0);
        check("alu_idle_at_done", {alu_a, alu_b, 12'd0, alu_control}, 0);
        check("stale_alu_drive", stale, 0);
        if (o == 3'd0) check("shl_ctl_cycles", shl_cycles, exp_n);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result, exp_r);
        $display("op=%0d a=%04h b=%04h -> result=%04h zero=%0d latency=%0d (exp %04h/%0d)%s",
                 o, a, b, result, zero, cycles, exp_r, exp_n, hammer ? " hammered" : "");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; opa = 16'd0; opb = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_alu", {alu_a, alu_b, 12'd0, alu_control}, 0);
        @(negedge clk); reset = 1'b0;

        issue(3'd0, 16'h0001, 16'd4, 1'b0);
        issue(3'd2, 16'h8000, 16'd3, 1'b0);
        issue(3'd1, 16'h8000, 16'd3, 1'b0);
        issue(3'd0, 16'h0101, 16'h0013, 1'b0);
        issue(3'd3, 16'h0123, 16'h0045, 1'b0);
        issue(3'd3, 16'hFFFF, 16'hFFFF, 1'b0);
        issue(3'd1, 16'hBEEF, 16'h0010, 1'b0);
        issue(3'd5, 16'h1234, 16'h0003, 1'b0);
        issue(3'd3, 16'h4321, 16'h0000, 1'b0);
        issue(3'd3, 16'h0123, 16'h0045, 1'b1);
        issue(3'd2, 16'h9ABC, 16'h0005, 1'b0);

        for (int t = 0; t < 40; t++)
            issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0);

        // Reset in the middle of a multiply.
        issue(3'd0, 16'h0003, 16'd2, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd3; opa = 16'h1234; opb = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy_mid_mul", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_zero", zero, 0);
        check("midrst_alu", {alu_a, alu_b, 12'd0, alu_control}, 0);
        $display("reset asserted mid-MUL: busy=%0d done=%0d result=%04h zero=%0d", busy, done, result, zero);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(3'd0, 16'h00FF, 16'd8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
